// File: rtl/rv32i_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// FSM state encoding, default memory index width and small decode helpers.
package rv32i_lsu_pkg;

    // Default word-index width of the attached data memory (512 words)
    localparam int ADDR_W_DEFAULT = 9;

    // funct3 encodings (loads and stores share the size codes)
    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } lsu_state_t;

    // Stores only allow B/H/W; loads additionally allow the unsigned forms
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic legal;
        legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return legal;
    endfunction

    // Access size in bytes, derived from the low two funct3 bits
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        logic [2:0] size;
        case (f3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit. Stores are shifted
// into a 64-bit two-word window (low word = first access, high word = the
// following word); loads are gathered from the same window, then extended.
module lsu_align
    import rv32i_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata_lo,
    input  logic [31:0] i_rdata_hi,
    output logic        o_split,
    output logic [3:0]  o_be_lo,
    output logic [3:0]  o_be_hi,
    output logic [31:0] o_wdata_lo,
    output logic [31:0] o_wdata_hi,
    output logic [31:0] o_rdata_ext
);

    logic [3:0]  w_end;
    logic [3:0]  w_mask;
    logic [7:0]  w_be_wide;
    logic [63:0] w_wdata_wide;
    logic [31:0] w_rd_raw;

    // An access is split when its last byte falls past the end of the word
    assign w_end   = {2'b00, i_offset} + {1'b0, f3_size(i_funct3)};
    assign o_split = (w_end > 4'd4);

    // Byte mask for the access size, before shifting to the offset
    always_comb begin
        w_mask = 4'b1111;
        case (i_funct3[1:0])
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    assign w_be_wide    = {4'b0000, w_mask} << i_offset;
    assign w_wdata_wide = {32'b0, i_wdata} << {i_offset, 3'b000};

    assign o_be_lo    = w_be_wide[3:0];
    assign o_be_hi    = w_be_wide[7:4];
    assign o_wdata_lo = w_wdata_wide[31:0];
    assign o_wdata_hi = w_wdata_wide[63:32];

    // Little-endian gather: bring the first byte of the access to lane 0
    assign w_rd_raw = 32'({i_rdata_hi, i_rdata_lo} >> {i_offset, 3'b000});

    // Sign- or zero-extend the gathered bytes according to funct3
    always_comb begin
        o_rdata_ext = 32'b0;
        case (i_funct3)
            F3_B:    o_rdata_ext = {{24{w_rd_raw[7]}}, w_rd_raw[7:0]};
            F3_H:    o_rdata_ext = {{16{w_rd_raw[15]}}, w_rd_raw[15:0]};
            F3_W:    o_rdata_ext = w_rd_raw;
            F3_BU:   o_rdata_ext = {24'b0, w_rd_raw[7:0]};
            F3_HU:   o_rdata_ext = {16'b0, w_rd_raw[15:0]};
            default: o_rdata_ext = 32'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit. Accepts one operation at a time,
// performs one word access (or two for a misaligned access that crosses a
// word boundary) and returns a single-cycle response.
module load_store_unit
    import rv32i_lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t r_state;
    lsu_state_t w_state_next;

    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_lo;

    logic        w_accept;
    logic        w_legal;
    logic        w_hi_word;
    logic        w_split;
    logic        w_latch_lo;
    logic        w_mem_we;
    logic [3:0]  w_mem_be;
    logic        w_rsp_valid;
    logic [3:0]  w_be_lo;
    logic [3:0]  w_be_hi;
    logic [31:0] w_wdata_lo;
    logic [31:0] w_wdata_hi;
    logic [31:0] w_rdata_lo;
    logic [31:0] w_rdata_hi;
    logic [31:0] w_rdata_ext;
    logic        w_unused_addr;

    // Address bits above the attached memory never reach it
    assign w_unused_addr = ^req_addr[31:ADDR_W+2];

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_legal   = f3_legal(r_we, r_funct3);
    assign w_hi_word = (r_state == ACC1);

    // In ACC1 the low part comes from the holding register, the high part live
    assign w_rdata_lo = w_hi_word ? r_lo : mem_rdata;
    assign w_rdata_hi = w_hi_word ? mem_rdata : 32'b0;

    lsu_align u_align (
        .i_funct3   (r_funct3),
        .i_offset   (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_rdata_lo (w_rdata_lo),
        .i_rdata_hi (w_rdata_hi),
        .o_split    (w_split),
        .o_be_lo    (w_be_lo),
        .o_be_hi    (w_be_hi),
        .o_wdata_lo (w_wdata_lo),
        .o_wdata_hi (w_wdata_hi),
        .o_rdata_ext(w_rdata_ext)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the request on accept; ignored at all other times
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b0;
            r_addr   <= '0;
            r_wdata  <= 32'b0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[ADDR_W+1:0];
            r_wdata  <= req_wdata;
        end
    end

    // Hold the first word of a split load for assembly in ACC1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo <= 32'b0;
        end else if (w_latch_lo) begin
            r_lo <= mem_rdata;
        end
    end

    // Next-state and memory/response strobes
    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_be     = 4'b0;
        w_rsp_valid  = 1'b0;
        w_latch_lo   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = ACC0;
                end
            end
            ACC0: begin
                if (!w_legal) begin
                    w_rsp_valid  = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    if (r_we) begin
                        w_mem_we = 1'b1;
                        w_mem_be = w_be_lo;
                    end
                    if (w_split) begin
                        w_latch_lo   = !r_we;
                        w_state_next = ACC1;
                    end else begin
                        w_rsp_valid  = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            ACC1: begin
                if (r_we) begin
                    w_mem_we = 1'b1;
                    w_mem_be = w_be_hi;
                end
                w_rsp_valid  = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Second access targets the next word, wrapping at the top of memory
    assign mem_addr  = r_addr[ADDR_W+1:2] + {{(ADDR_W-1){1'b0}}, w_hi_word};
    assign mem_wdata = w_hi_word ? w_wdata_hi : w_wdata_lo;

    // Reset suppresses any further write or response immediately
    assign mem_we    = w_mem_we & ~rst;
    assign mem_be    = rst ? 4'b0 : w_mem_be;
    assign rsp_valid = w_rsp_valid & ~rst;
    assign rsp_err   = rsp_valid & ~w_legal;
    assign rsp_rdata = (rsp_valid && w_legal && !r_we) ? w_rdata_ext : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases followed by
// random operations, checked against a byte-addressed reference memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    load_store_unit #(.ADDR_W(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory attached to the DUT
    logic [31:0] dmem [512];
    logic [31:0] wr_merged;
    logic        mem_init;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] x;
        x = i;
        return (x * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    assign mem_rdata = dmem[mem_addr];

    always_comb begin
        wr_merged = dmem[mem_addr];
        for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) wr_merged[8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) dmem[i] <= init_word(i);
        end else if (mem_we) begin
            dmem[mem_addr] <= wr_merged;
        end
    end

    // Reference model: flat byte array, 2048 bytes, addresses wrap
    logic [7:0] ref_mem [2048];

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int lat, output int nwr);
        int   size;
        int   off;
        int   idx;
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(addr[1:0]);
        rd    = 32'b0;
        err   = !legal;
        lat   = 1;
        nwr   = 0;
        if (legal) begin
            lat = (off + size > 4) ? 2 : 1;
            for (int k = 0; k < size; k++) begin
                idx = int'((addr + k) & 32'h7FF);
                if (we) ref_mem[idx] = wd[8*k +: 8];
                else    rd[8*k +: 8] = ref_mem[idx];
            end
            if (we) nwr = lat;
            else if (!f3[2]) begin
                if (size == 1)      rd = {{24{rd[7]}}, rd[7:0]};
                else if (size == 2) rd = {{16{rd[15]}}, rd[15:0]};
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Observations of the most recent transaction
    int          o_lat;
    int          o_nwr;
    logic [31:0] o_rdata;
    logic        o_err;
    logic [8:0]  o_waddr [2];
    logic [3:0]  o_wbe   [2];
    logic [31:0] o_wdata [2];
    logic [8:0]  o_aaddr [2];

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        o_lat = 0; o_nwr = 0; o_rdata = 32'b0; o_err = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            if (cyc <= 2) o_aaddr[cyc-1] = mem_addr;
            if (mem_we) begin
                if (o_nwr < 2) begin
                    o_waddr[o_nwr] = mem_addr;
                    o_wbe[o_nwr]   = mem_be;
                    o_wdata[o_nwr] = mem_wdata;
                end
                o_nwr++;
            end
            if (rsp_valid) begin
                o_lat   = cyc;
                o_rdata = rsp_rdata;
                o_err   = rsp_err;
                break;
            end
        end
        $display("op we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> lat=%0d rdata=0x%08h err=%0d writes=%0d",
                 we, f3, addr, wd, o_lat, o_rdata, o_err, o_nwr);
    endtask

    task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
        int          e_nwr;
        model(we, f3, addr, wd, e_rd, e_err, e_lat, e_nwr);
        run_op(we, f3, addr, wd);
        chk({tag, "_lat"},   o_lat,   e_lat);
        chk({tag, "_err"},   {31'b0, o_err}, {31'b0, e_err});
        chk({tag, "_rdata"}, o_rdata, e_rd);
        chk({tag, "_nwr"},   o_nwr,   e_nwr);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] ra;
        logic [31:0] rw;

        rst        = 1'b1;
        mem_init   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'b0;
        req_wdata  = 32'b0;
        for (int i = 0; i < 512; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        chk("rst_rsp_rdata", rsp_rdata,          32'd0);
        chk("rst_mem_we",    {31'b0, mem_we},    32'd0);
        chk("rst_mem_be",    {28'b0, mem_be},    32'd0);

        // Aligned word store
        do_op("sw_aligned", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_aligned_lat1",  o_lat,            32'd1);
        chk("sw_aligned_addr",  {23'b0, o_waddr[0]}, 32'd4);
        chk("sw_aligned_be",    {28'b0, o_wbe[0]},   32'hF);
        chk("sw_aligned_wdata", o_wdata[0],       32'hDEADBEEF);

        // Byte store in lane 3, then signed and unsigned byte loads
        do_op("sb_lane3", 1'b1, 3'b000, 32'h13, 32'h000000A5);
        chk("sb_lane3_be",   {28'b0, o_wbe[0]}, 32'h8);
        chk("sb_lane3_byte", o_wdata[0] >> 24,  32'hA5);
        do_op("lb_lane3", 1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_lane3_val", o_rdata, 32'hFFFFFFA5);
        do_op("lbu_lane3", 1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu_lane3_val", o_rdata, 32'h000000A5);

        // Split word store and load across words 1 and 2
        do_op("sw_split", 1'b1, 3'b010, 32'h06, 32'h11223344);
        chk("sw_split_addr0", {23'b0, o_waddr[0]}, 32'd1);
        chk("sw_split_be0",   {28'b0, o_wbe[0]},   32'hC);
        chk("sw_split_hi16",  o_wdata[0] >> 16,    32'h3344);
        chk("sw_split_addr1", {23'b0, o_waddr[1]}, 32'd2);
        chk("sw_split_be1",   {28'b0, o_wbe[1]},   32'h3);
        chk("sw_split_lo16",  o_wdata[1] & 32'hFFFF, 32'h1122);
        do_op("lw_split", 1'b0, 3'b010, 32'h06, 32'h0);
        chk("lw_split_val", o_rdata, 32'h11223344);
        chk("lw_split_lat", o_lat,   32'd2);

        // Halfword load straddling the top of memory
        do_op("sb_top",  1'b1, 3'b000, 32'h7FF, 32'h00000080);
        do_op("sb_zero", 1'b1, 3'b000, 32'h000, 32'h0000007F);
        do_op("lh_wrap", 1'b0, 3'b001, 32'h7FF, 32'h0);
        chk("lh_wrap_addr0", {23'b0, o_aaddr[0]}, 32'h1FF);
        chk("lh_wrap_addr1", {23'b0, o_aaddr[1]}, 32'h000);
        chk("lh_wrap_val",   o_rdata, 32'h00007F80);

        // Illegal funct3 for load and store
        do_op("ld_f3_011", 1'b0, 3'b011, 32'h20, 32'h0);
        chk("ld_f3_011_err", {31'b0, o_err}, 32'd1);
        chk("ld_f3_011_nwr", o_nwr, 32'd0);
        do_op("st_f3_100", 1'b1, 3'b100, 32'h24, 32'hFFFFFFFF);
        chk("st_f3_100_err", {31'b0, o_err}, 32'd1);
        chk("st_f3_100_nwr", o_nwr, 32'd0);

        // Reset during the second half of a split store
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0A;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_acc0_we", {31'b0, mem_we}, 32'd1);
        ref_mem[32'h0A] = 8'h0D;
        ref_mem[32'h0B] = 8'hF0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_acc1_we",    {31'b0, mem_we},    32'd0);
        chk("rstmid_acc1_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
        chk("rstmid_valid", {31'b0, rsp_valid}, 32'd0);
        $display("reset during split store checked");
        do_op("rstmid_lw_lo", 1'b0, 3'b010, 32'h08, 32'h0);
        do_op("rstmid_lw_hi", 1'b0, 3'b010, 32'h0C, 32'h0);

        // Random operations
        for (int n = 0; n < 120; n++) begin
            ra = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 47)) : $urandom;
            rw = $urandom;
            do_op("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rw);
        end

        // Whole memory image against the reference bytes
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[4*i + b];
            chk("mem_image", dmem[i], w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
